// File: rtl/selector.sv
// Registered LED display selector: ALU result, operand pair, compare flags
// or running accumulator. Accumulator built only when SELECTOR_ACC_EN is defined.
module selector (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] select,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] opCodeA,
  output logic [7:0] s0
);

  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] alu;
  logic [7:0] cmp;
  logic [7:0] s0_d;
  logic [7:0] s0_q;

  assign a8 = {4'h0, A};
  assign b8 = {4'h0, B};

  // Combinational 8-op ALU, all results wrap mod 256
  always_comb begin
    alu = 8'h00;
    unique case (opCodeA)
      3'b000:  alu = a8 + b8;
      3'b001:  alu = a8 - b8;
      3'b010:  alu = a8 & b8;
      3'b011:  alu = a8 | b8;
      3'b100:  alu = a8 ^ b8;
      3'b101:  alu = {4'h0, ~A};
      3'b110:  alu = a8 << B[2:0];
      3'b111:  alu = a8 * b8;
      default: alu = 8'h00;
    endcase
  end

  // Magnitude compare flags, exactly one low bit set
  always_comb begin
    cmp = {5'b0, (A > B), (A == B), (A < B)};
  end

`ifdef SELECTOR_ACC_EN
  logic [7:0] acc_d;
  logic [7:0] acc_q;

  // Output mux; accumulator advances only on the accumulate select
  always_comb begin
    s0_d  = 8'h00;
    acc_d = acc_q;
    case (select)
      4'b0001: s0_d = alu;
      4'b0010: s0_d = {A, B};
      4'b0100: s0_d = cmp;
      4'b1000: begin
        acc_d = acc_q + alu;
        s0_d  = acc_q + alu;
      end
      default: s0_d = 8'h00;
    endcase
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 8'h00;
    else     acc_q <= acc_d;
  end
`else
  // Output mux; the accumulate select is invalid in this build
  always_comb begin
    s0_d = 8'h00;
    case (select)
      4'b0001: s0_d = alu;
      4'b0010: s0_d = {A, B};
      4'b0100: s0_d = cmp;
      default: s0_d = 8'h00;
    endcase
  end
`endif

  // Display output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s0_q <= 8'h00;
    else     s0_q <= s0_d;
  end

  assign s0 = s0_q;

endmodule

// File: tb/tb_selector.sv
// Self-checking bench for selector: directed plan plus random
// stimulus against an arithmetic reference model.
module tb_selector;

  logic       clk;
  logic       rst;
  logic [3:0] select;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opCodeA;
  logic [7:0] s0;

  int total;
  int bad;
  int acc_m;

  selector dut (
    .clk     (clk),
    .rst     (rst),
    .select  (select),
    .A       (A),
    .B       (B),
    .opCodeA (opCodeA),
    .s0      (s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask

  function automatic int alu_ref(int a, int b, int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 15 - a;
      6: return (a * (1 << (b % 8))) % 256;
      default: return (a * b) % 256;
    endcase
  endfunction

  // Expected s0 after one edge; advances the model accumulator
  function automatic int model(int sel, int a, int b, int op);
    int r;
    r = alu_ref(a, b, op);
    if (sel == 1) return r;
    if (sel == 2) return a * 16 + b;
    if (sel == 4) return (a > b) ? 4 : ((a == b) ? 2 : 1);
`ifdef SELECTOR_ACC_EN
    if (sel == 8) begin
      acc_m = (acc_m + r) % 256;
      return acc_m;
    end
`endif
    return 0;
  endfunction

  task automatic step(input string tag, input int sel, input int a,
                      input int b, input int op);
    int e;
    @(negedge clk);
    select  = 4'(sel);
    A       = 4'(a);
    B       = 4'(b);
    opCodeA = 3'(op);
    e = model(sel, a, b, op);
    @(posedge clk);
    #1;
    chk(tag, s0, 8'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    acc_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int sels[8];
    total = 0;
    bad   = 0;
    acc_m = 0;
    rst = 1'b1;
    select = 4'h0;
    A = 4'h0;
    B = 4'h0;
    opCodeA = 3'h0;
    #2;
    chk("reset_init", s0, 8'h00);
    do_reset();

    step("alu_mul", 1, 1, 2, 7);
    chk("alu_mul_k", s0, 8'h02);
    step("alu_sub", 1, 1, 2, 1);
    chk("alu_sub_k", s0, 8'hFF);
    step("alu_add", 1, 1, 2, 0);
    step("alu_shl", 1, 1, 2, 6);
    chk("alu_shl_k", s0, 8'h04);
    step("alu_mulff", 1, 15, 15, 7);
    chk("alu_mulff_k", s0, 8'hE1);
    step("alu_not", 1, 5, 0, 5);
    step("alu_shl_ovf", 1, 15, 7, 6);

    step("cat", 2, 1, 2, 0);
    chk("cat_k", s0, 8'h12);
    step("cmp_lt", 4, 1, 2, 0);
    step("cmp_eq", 4, 5, 5, 0);
    chk("cmp_eq_k", s0, 8'h02);
    step("cmp_gt", 4, 9, 3, 0);

    // Async reset mid-cycle with s0 = 12
    step("pre_rst", 2, 1, 2, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    acc_m = 0;
    #1;
    chk("rst_async", s0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold", s0, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    step("acc1", 8, 1, 2, 7);
    step("acc2", 8, 1, 2, 7);
    step("acc3", 8, 1, 2, 7);
`ifdef SELECTOR_ACC_EN
    chk("acc3_k", s0, 8'h06);
`else
    chk("noacc_k", s0, 8'h00);
`endif
    step("away1", 1, 1, 2, 7);
    step("away2", 1, 1, 2, 7);
    step("acc_resume", 8, 1, 2, 7);
`ifdef SELECTOR_ACC_EN
    chk("acc_resume_k", s0, 8'h08);
`endif
    step("inv0", 0, 1, 2, 7);
    step("inv3", 3, 1, 2, 7);
    step("invF", 15, 1, 2, 7);
    step("acc_after_inv", 8, 1, 2, 7);

    // Drive acc to FE then wrap with +2
    do_reset();
    step("pre_e1", 8, 15, 15, 7);
    step("pre_fe", 8, 14, 15, 0);
    step("wrap", 8, 1, 1, 0);
`ifdef SELECTOR_ACC_EN
    chk("wrap_k", s0, 8'h00);
`endif

    sels = '{1, 2, 4, 8, 0, 3, 15, 8};
    for (int i = 0; i < 400; i++) begin
      int s;
      if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 15);
      else s = sels[$urandom_range(0, 7)];
      step("rand", s, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
